// File: rtl/rec_sweep_pkg.sv
// Shared types and constants for the 3-input function sweeper and its bench.
package rec_sweep_pkg;

  localparam int N_IN  = 3;
  localparam int N_VEC = 8;

  // Known-good truth table of s = (~a | b) & (b | ~c), bit i = vector i.
  localparam logic [N_VEC-1:0] REF_TABLE = 8'hCD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rec_func3.sv
// Combinational datapath under test: s = (~a | b) & (b | ~c).
module rec_func3 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s
);

  assign s = (~a | b) & (b | ~c);

endmodule

// File: rtl/rec_func_sweeper.sv
// Sweeps rec_func3 over all 8 input vectors, captures its truth table and
// compares it against a caller-supplied expected table.
//
// Handshake: start is sampled only while idle (busy=0, done=0); an accepted
// start raises busy on the same edge, and done pulses for exactly one cycle
// once table_out/mismatch/err_count/fault_idx hold the new results.
module rec_func_sweeper
  import rec_sweep_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [N_VEC-1:0]    expected,
  output logic                busy,
  output logic                done,
  output logic [N_IN-1:0]     vec,
  output logic [N_VEC-1:0]    table_out,
  output logic                mismatch,
  output logic [3:0]          err_count,
  output logic [N_IN-1:0]     fault_idx,
  output state_e              state_dbg
);

  function automatic logic [3:0] popcount(input logic [N_VEC-1:0] d);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < N_VEC; i++) cnt = cnt + {3'b000, d[i]};
    return cnt;
  endfunction

  // Scanning downward leaves the lowest set index as the final winner.
  function automatic logic [N_IN-1:0] lowest_set(input logic [N_VEC-1:0] d);
    logic [N_IN-1:0] idx;
    idx = '0;
    for (int i = N_VEC - 1; i >= 0; i--) begin
      if (d[i]) idx = i[N_IN-1:0];
    end
    return idx;
  endfunction

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [N_VEC-1:0]  exp_q, exp_d;
  logic [N_VEC-1:0]  table_q, table_d;
  logic              mism_q, mism_d;
  logic [3:0]        errc_q, errc_d;
  logic [N_IN-1:0]   fidx_q, fidx_d;
  logic              s;
  logic [N_VEC-1:0]  diff;

  rec_func3 u_func (
    .a (idx_q[2]),
    .b (idx_q[1]),
    .c (idx_q[0]),
    .s (s)
  );

  assign diff = table_q ^ exp_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    exp_d   = exp_q;
    table_d = table_q;
    mism_d  = mism_q;
    errc_d  = errc_q;
    fidx_d  = fidx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          idx_d   = '0;
          exp_d   = expected;
          table_d = '0;
        end
      end
      SWEEP: begin
        table_d[idx_q] = s;
        idx_d          = idx_q + 3'd1;
        if (idx_q == 3'(N_VEC - 1)) state_d = CHECK;
      end
      CHECK: begin
        mism_d  = |diff;
        errc_d  = popcount(diff);
        fidx_d  = lowest_set(diff);
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mism_q  <= 1'b0;
      errc_q  <= 4'd0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      mism_q  <= mism_d;
      errc_q  <= errc_d;
      fidx_q  <= fidx_d;
    end
  end

  assign busy      = (state_q == SWEEP) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign vec       = (state_q == SWEEP) ? idx_q : '0;
  assign table_out = table_q;
  assign mismatch  = mism_q;
  assign err_count = errc_q;
  assign fault_idx = fidx_q;
  assign state_dbg = state_q;

endmodule
